sprite_mover: RTL

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - frame-ticked bouncing sprite position generator
// Each vsync rise runs IDLE->CALC_X->CALC_Y->COMMIT through one shared 17-bit adder.
module sprite_mover #(
    parameter int                 SCREEN_W   = 800,
    parameter int                 SCREEN_H   = 600,
    parameter int                 SPR_W      = 16,
    parameter int                 SPR_H      = 16,
    parameter logic signed [15:0] INIT_X_VEL = 16'sd5,
    parameter logic signed [15:0] INIT_Y_VEL = 16'sd6
) (
    input  logic               i_pix_clk,
    input  logic               i_reset_n,
    input  logic               i_vert_sync,
    input  logic               i_enable,
    input  logic               i_vel_valid,
    output logic               o_vel_ready,
    input  logic signed [15:0] i_x_vel,
    input  logic signed [15:0] i_y_vel,
    output logic signed [15:0] o_x_coord,
    output logic signed [15:0] o_y_coord,
    output logic               o_bounce_x,
    output logic               o_bounce_y,
    output logic        [15:0] o_frame_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC_X = 2'd1;
    localparam logic [1:0] CALC_Y = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic signed [16:0] MAX_X = 17'(SCREEN_W - SPR_W);
    localparam logic signed [16:0] MAX_Y = 17'(SCREEN_H - SPR_H);

    logic [1:0]         state_q, state_d;
    logic               vs_q, vs_d;
    logic signed [15:0] x_q, x_d, y_q, y_d;
    logic signed [15:0] x_vel_q, x_vel_d, y_vel_q, y_vel_d;
    logic signed [15:0] shx_q, shx_d, shy_q, shy_d;
    logic               hit_x_q, hit_x_d, hit_y_q, hit_y_d;
    logic               bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
    logic        [15:0] frame_q, frame_d;

    logic               tick;
    logic signed [15:0] cur_pos, cur_vel, neg_vel, step_pos, step_vel;
    logic signed [16:0] cur_max, sum;
    logic               step_hit;

    assign tick          = i_vert_sync & ~vs_q;
    assign o_vel_ready   = (state_q == IDLE);
    assign o_x_coord     = x_q;
    assign o_y_coord     = y_q;
    assign o_bounce_x    = bounce_x_q;
    assign o_bounce_y    = bounce_y_q;
    assign o_frame_count = frame_q;

    // One axis step per calc state; the axis is selected by the current state.
    always_comb begin
        cur_pos  = (state_q == CALC_Y) ? y_q     : x_q;
        cur_vel  = (state_q == CALC_Y) ? y_vel_q : x_vel_q;
        cur_max  = (state_q == CALC_Y) ? MAX_Y   : MAX_X;
        sum      = {cur_pos[15], cur_pos} + {cur_vel[15], cur_vel};
        neg_vel  = (cur_vel == 16'sh8000) ? 16'sh7fff : -cur_vel;
        step_pos = sum[15:0];
        step_vel = cur_vel;
        step_hit = 1'b0;
        if (sum > cur_max) begin
            step_pos = cur_max[15:0];
            step_vel = neg_vel;
            step_hit = 1'b1;
        end else if (sum < 17'sd0) begin
            step_pos = 16'sd0;
            step_vel = neg_vel;
            step_hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        vs_d       = i_vert_sync;
        x_d        = x_q;
        y_d        = y_q;
        x_vel_d    = x_vel_q;
        y_vel_d    = y_vel_q;
        shx_d      = shx_q;
        shy_d      = shy_q;
        hit_x_d    = hit_x_q;
        hit_y_d    = hit_y_q;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        frame_d    = frame_q;
        case (state_q)
            IDLE: begin
                if (i_vel_valid) begin
                    x_vel_d = i_x_vel;
                    y_vel_d = i_y_vel;
                end
                if (tick && i_enable) state_d = CALC_X;
            end
            CALC_X: begin
                shx_d   = step_pos;
                x_vel_d = step_vel;
                hit_x_d = step_hit;
                state_d = CALC_Y;
            end
            CALC_Y: begin
                shy_d   = step_pos;
                y_vel_d = step_vel;
                hit_y_d = step_hit;
                state_d = COMMIT;
            end
            COMMIT: begin
                x_d        = shx_q;
                y_d        = shy_q;
                bounce_x_d = hit_x_q;
                bounce_y_d = hit_y_q;
                frame_d    = frame_q + 16'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vs_q resets high so a vsync already asserted at release is not a tick.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            vs_q       <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            x_vel_q    <= INIT_X_VEL;
            y_vel_q    <= INIT_Y_VEL;
            shx_q      <= '0;
            shy_q      <= '0;
            hit_x_q    <= 1'b0;
            hit_y_q    <= 1'b0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_vel_q    <= x_vel_d;
            y_vel_q    <= y_vel_d;
            shx_q      <= shx_d;
            shy_q      <= shy_d;
            hit_x_q    <= hit_x_d;
            hit_y_q    <= hit_y_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
            frame_q    <= frame_d;
        end
    end
endmodule
